// File: rtl/mem_stage_if.sv
// Data-memory bus between the memory stage (master) and the multi-cycle
// data memory (slave). Request/done handshake with a busy back-pressure.
interface mem_stage_if;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_rdata;
  logic        mem_busy;
  logic        mem_done;

  modport master (
    output mem_addr, mem_wdata, mem_en, mem_wr,
    input  mem_rdata, mem_busy, mem_done
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_en, mem_wr,
    output mem_rdata, mem_busy, mem_done
  );
endinterface

// File: rtl/mem_stage.sv
// Pipeline memory stage: issues LD/ST/STU to a multi-cycle data memory,
// stalls the upstream pipe while an access is outstanding, and loads the
// MEM/WB pipe register.
// Optional access/stall performance counters: define MEM_STAGE_PERF_EN.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | no access outstanding; a clean memory op issues from here
// S_WAIT_RDY  | memory op pending, memory busy; request held back
// S_WAIT_DONE | request issued; waiting for mem_done or timeout
module mem_stage #(
  parameter int          TIMEOUT_CYCLES = 64,
  parameter logic [15:0] NOP_INSTR      = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instruction_in,
  input  logic [15:0] Xcomp_in,
  input  logic [15:0] Binput_in,
  input  logic        RegWrt_in,
  input  logic        unaligned_error_in,
  mem_stage_if.master mem,
  output logic        mem_stall,
  output logic [15:0] instruction_out,
  output logic [15:0] WData_out,
  output logic        RegWrt_out,
  output logic        err_out
`ifdef MEM_STAGE_PERF_EN
  ,
  output logic [15:0] perf_access_cnt,
  output logic [15:0] perf_stall_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_RDY, S_WAIT_DONE} state_e;

  localparam logic [6:0] TO_LAST = 7'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        regwrt_q, regwrt_d;
  logic        err_q, err_d;

  logic [4:0] opcode;
  logic       is_ld, is_st, is_mem;
  logic       acc_err, go, done, timeout, err_all;

  // Decode, error qualification, handshake and stall generation.
  // mem_en is decoded from state so a clean access issues in the same cycle
  // the instruction arrives (2-cycle minimum latency).
  always_comb begin
    opcode  = instruction_in[15:11];
    is_ld   = (opcode == 5'b10001);
    is_st   = (opcode == 5'b10000) || (opcode == 5'b10011);
    is_mem  = is_ld | is_st;
    acc_err = unaligned_error_in | (is_mem & Xcomp_in[0]);
    go      = is_mem & ~acc_err;
    done    = (state_q == S_WAIT_DONE) & mem.mem_done;
    timeout = (state_q == S_WAIT_DONE) & (cnt_q == TO_LAST) & ~mem.mem_done;
    err_all = acc_err | timeout;

    mem_stall     = go & ~(done | timeout);
    mem.mem_addr  = Xcomp_in;
    mem.mem_wdata = Binput_in;
    mem.mem_en    = rst & go & ~mem.mem_busy &
                    ((state_q == S_IDLE) | (state_q == S_WAIT_RDY));
    mem.mem_wr    = mem.mem_en & is_st;
  end

  // Next state and timeout counter; the counter saturates rather than wraps.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (go) state_d = mem.mem_busy ? S_WAIT_RDY : S_WAIT_DONE;
      end
      S_WAIT_RDY: begin
        if (!go)                state_d = S_IDLE;
        else if (!mem.mem_busy) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (done || timeout) state_d = S_IDLE;
        else cnt_d = (cnt_q == 7'h7F) ? cnt_q : cnt_q + 7'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // MEM/WB pipe register next values: bubble while stalled.
  // A load that produced no data (error or timeout) writes back zero.
  always_comb begin
    instr_d  = instruction_in;
    wdata_d  = wdata_q;
    regwrt_d = RegWrt_in & ~err_all;
    err_d    = err_all;
    if (mem_stall) begin
      instr_d  = NOP_INSTR;
      regwrt_d = 1'b0;
      err_d    = 1'b0;
    end else if (is_ld) begin
      wdata_d = done ? mem.mem_rdata : 16'h0000;
    end else begin
      wdata_d = Xcomp_in;
    end
  end

  // FSM state, timeout counter and MEM/WB pipe registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      instr_q  <= NOP_INSTR;
      wdata_q  <= '0;
      regwrt_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      instr_q  <= instr_d;
      wdata_q  <= wdata_d;
      regwrt_q <= regwrt_d;
      err_q    <= err_d;
    end
  end

  assign instruction_out = instr_q;
  assign WData_out       = wdata_q;
  assign RegWrt_out      = regwrt_q;
  assign err_out         = err_q;

`ifdef MEM_STAGE_PERF_EN
  logic [15:0] acc_cnt_q, acc_cnt_d;
  logic [15:0] stl_cnt_q, stl_cnt_d;

  // Saturating access and stall-cycle counters.
  always_comb begin
    acc_cnt_d = acc_cnt_q;
    stl_cnt_d = stl_cnt_q;
    if (mem.mem_en && acc_cnt_q != 16'hFFFF) acc_cnt_d = acc_cnt_q + 16'd1;
    if (mem_stall && stl_cnt_q != 16'hFFFF)  stl_cnt_d = stl_cnt_q + 16'd1;
  end

  // Performance counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_cnt_q <= '0;
      stl_cnt_q <= '0;
    end else begin
      acc_cnt_q <= acc_cnt_d;
      stl_cnt_q <= stl_cnt_d;
    end
  end

  assign perf_access_cnt = acc_cnt_q;
  assign perf_stall_cnt  = stl_cnt_q;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage (TIMEOUT_CYCLES=8): a per-cycle vector table
// plus hand-written timeout and reset-abandon sequences.
module tb_mem_stage;
  logic        clk;
  logic        rst;
  logic [15:0] instruction_in;
  logic [15:0] Xcomp_in;
  logic [15:0] Binput_in;
  logic        RegWrt_in;
  logic        unaligned_error_in;
  logic        mem_stall;
  logic [15:0] instruction_out;
  logic [15:0] WData_out;
  logic        RegWrt_out;
  logic        err_out;

  mem_stage_if mif ();

  mem_stage #(.TIMEOUT_CYCLES(8), .NOP_INSTR(16'h0800)) dut (
    .clk                (clk),
    .rst                (rst),
    .instruction_in     (instruction_in),
    .Xcomp_in           (Xcomp_in),
    .Binput_in          (Binput_in),
    .RegWrt_in          (RegWrt_in),
    .unaligned_error_in (unaligned_error_in),
    .mem                (mif),
    .mem_stall          (mem_stall),
    .instruction_out    (instruction_out),
    .WData_out          (WData_out),
    .RegWrt_out         (RegWrt_out),
    .err_out            (err_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [15:0] instr;
    logic [15:0] xcomp;
    logic [15:0] bin;
    logic        rw;
    logic        unal;
    logic        busy;
    logic        done;
    logic [15:0] rdata;
    logic        stall;
    logic        en;
    logic        wr;
    logic [15:0] io;
    logic [15:0] wd;
    logic        wd_chk;
    logic        rwo;
    logic        err;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  task automatic drive(input logic [15:0] ins, input logic [15:0] x, input logic [15:0] b,
                       input logic rw, input logic un, input logic busy, input logic done,
                       input logic [15:0] rd);
    instruction_in     = ins;
    Xcomp_in           = x;
    Binput_in          = b;
    RegWrt_in          = rw;
    unaligned_error_in = un;
    mif.mem_busy       = busy;
    mif.mem_done       = done;
    mif.mem_rdata      = rd;
  endtask

  int nstall;
  int nen;

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // instr  xcomp  bin   rw un by dn rdata   st en wr io     wd    wc rw er
    vecs[0]  = '{16'hD9A0, 16'h1234, 16'h0000, 1, 0, 0, 0, 16'h0000, 0, 0, 0, 16'hD9A0, 16'h1234, 1, 1, 0};
    vecs[1]  = '{16'h8840, 16'h0100, 16'h0000, 1, 0, 0, 0, 16'h0000, 1, 1, 0, 16'h0800, 16'h0000, 0, 0, 0};
    vecs[2]  = '{16'h8840, 16'h0100, 16'h0000, 1, 0, 0, 0, 16'h0000, 1, 0, 0, 16'h0800, 16'h0000, 0, 0, 0};
    vecs[3]  = '{16'h8840, 16'h0100, 16'h0000, 1, 0, 0, 0, 16'h0000, 1, 0, 0, 16'h0800, 16'h0000, 0, 0, 0};
    vecs[4]  = '{16'h8840, 16'h0100, 16'h0000, 1, 0, 0, 1, 16'hBEEF, 0, 0, 0, 16'h8840, 16'hBEEF, 1, 1, 0};
    vecs[5]  = '{16'h8060, 16'h0200, 16'hCAFE, 0, 0, 1, 0, 16'h0000, 1, 0, 0, 16'h0800, 16'h0000, 0, 0, 0};
    vecs[6]  = '{16'h8060, 16'h0200, 16'hCAFE, 0, 0, 1, 0, 16'h0000, 1, 0, 0, 16'h0800, 16'h0000, 0, 0, 0};
    vecs[7]  = '{16'h8060, 16'h0200, 16'hCAFE, 0, 0, 0, 0, 16'h0000, 1, 1, 1, 16'h0800, 16'h0000, 0, 0, 0};
    vecs[8]  = '{16'h8060, 16'h0200, 16'hCAFE, 0, 0, 0, 1, 16'h0000, 0, 0, 0, 16'h8060, 16'h0200, 1, 0, 0};
    vecs[9]  = '{16'h9860, 16'h0204, 16'h1111, 1, 0, 0, 0, 16'h0000, 1, 1, 1, 16'h0800, 16'h0000, 0, 0, 0};
    vecs[10] = '{16'h9860, 16'h0204, 16'h1111, 1, 0, 0, 1, 16'h0000, 0, 0, 0, 16'h9860, 16'h0204, 1, 1, 0};
    vecs[11] = '{16'h8840, 16'h0003, 16'h0000, 1, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h8840, 16'h0000, 0, 0, 1};
    vecs[12] = '{16'h8840, 16'h0100, 16'h0000, 1, 1, 0, 0, 16'h0000, 0, 0, 0, 16'h8840, 16'h0000, 0, 0, 1};
    vecs[13] = '{16'hD9A0, 16'h0003, 16'h0000, 1, 0, 0, 0, 16'h0000, 0, 0, 0, 16'hD9A0, 16'h0003, 1, 1, 0};
    vecs[14] = '{16'h0800, 16'h0000, 16'h0000, 0, 0, 0, 1, 16'h0000, 0, 0, 0, 16'h0800, 16'h0000, 1, 0, 0};
    vecs[15] = '{16'h8060, 16'h0300, 16'h5555, 0, 0, 1, 1, 16'h0000, 1, 0, 0, 16'h0800, 16'h0000, 0, 0, 0};
    vecs[16] = '{16'h8060, 16'h0300, 16'h5555, 0, 0, 1, 1, 16'h0000, 1, 0, 0, 16'h0800, 16'h0000, 0, 0, 0};
    vecs[17] = '{16'h8060, 16'h0300, 16'h5555, 0, 0, 0, 0, 16'h0000, 1, 1, 1, 16'h0800, 16'h0000, 0, 0, 0};
    vecs[18] = '{16'h8060, 16'h0300, 16'h5555, 0, 0, 0, 1, 16'h0000, 0, 0, 0, 16'h8060, 16'h0300, 1, 0, 0};

    // Reset with a load sitting at the input: no request may leave.
    rst = 1'b0;
    drive(16'h8840, 16'h0100, 16'h0000, 1, 0, 0, 0, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_instr_out", instruction_out, 16'h0800);
    chk("rst_wdata",     WData_out, 16'h0000);
    chk("rst_regwrt",    16'(RegWrt_out), 16'h0);
    chk("rst_err",       16'(err_out), 16'h0);
    chk("rst_mem_en",    16'(mif.mem_en), 16'h0);
    drive(16'h0800, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Table: one row per cycle; comb outputs checked mid-cycle, pipe after edge.
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].instr, vecs[i].xcomp, vecs[i].bin, vecs[i].rw, vecs[i].unal,
            vecs[i].busy, vecs[i].done, vecs[i].rdata);
      #1;
      chk($sformatf("v%0d_stall", i), 16'(mem_stall), 16'(vecs[i].stall));
      chk($sformatf("v%0d_en", i),    16'(mif.mem_en), 16'(vecs[i].en));
      chk($sformatf("v%0d_wr", i),    16'(mif.mem_wr), 16'(vecs[i].wr));
      if (vecs[i].en) begin
        chk($sformatf("v%0d_addr", i),  mif.mem_addr, vecs[i].xcomp);
        chk($sformatf("v%0d_wdata", i), mif.mem_wdata, vecs[i].bin);
      end
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_instr_out", i), instruction_out, vecs[i].io);
      if (vecs[i].wd_chk) chk($sformatf("v%0d_wdata_out", i), WData_out, vecs[i].wd);
      chk($sformatf("v%0d_regwrt_out", i), 16'(RegWrt_out), 16'(vecs[i].rwo));
      chk($sformatf("v%0d_err_out", i),    16'(err_out), 16'(vecs[i].err));
    end

    // Load never answered: issue cycle + 7 stalled WAIT_DONE cycles, the 8th
    // WAIT_DONE cycle completes with a timeout.
    // Second pass: done arrives in that same last cycle and must win.
    for (int pass = 0; pass < 2; pass++) begin
      nstall = 0;
      nen    = 0;
      for (int k = 0; k <= 8; k++) begin
        drive(16'h8840, 16'h0400, 16'h0000, 1, 0, 0, (pass == 1) && (k == 8), 16'hA5A5);
        #1;
        if (mem_stall) nstall++;
        if (mif.mem_en) nen++;
        @(posedge clk);
        #1;
      end
      chk($sformatf("to%0d_stall_cycles", pass), 16'(nstall), 16'd8);
      chk($sformatf("to%0d_en_pulses", pass),    16'(nen), 16'd1);
      chk($sformatf("to%0d_instr_out", pass),    instruction_out, 16'h8840);
      chk($sformatf("to%0d_wdata_out", pass),    WData_out, (pass == 1) ? 16'hA5A5 : 16'h0000);
      chk($sformatf("to%0d_regwrt_out", pass),   16'(RegWrt_out), (pass == 1) ? 16'h1 : 16'h0);
      chk($sformatf("to%0d_err_out", pass),      16'(err_out), (pass == 1) ? 16'h0 : 16'h1);
    end

    // Reset in the middle of WAIT_DONE abandons the access.
    drive(16'h8840, 16'h0600, 16'h0000, 1, 0, 0, 0, 16'h0000);
    #1;
    chk("ra_issue_en", 16'(mif.mem_en), 16'h1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("ra_instr_out", instruction_out, 16'h0800);
    chk("ra_wdata",     WData_out, 16'h0000);
    chk("ra_regwrt",    16'(RegWrt_out), 16'h0);
    chk("ra_err",       16'(err_out), 16'h0);
    chk("ra_mem_en",    16'(mif.mem_en), 16'h0);
    drive(16'h0800, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000);
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    // Late done for the abandoned access must be ignored.
    drive(16'h0800, 16'h0000, 16'h0000, 0, 0, 0, 1, 16'h7777);
    #1;
    chk("ra_late_stall", 16'(mem_stall), 16'h0);
    chk("ra_late_en",    16'(mif.mem_en), 16'h0);
    @(posedge clk);
    #1;
    chk("ra_late_instr", instruction_out, 16'h0800);
    chk("ra_late_wdata", WData_out, 16'h0000);
    chk("ra_late_err",   16'(err_out), 16'h0);
    // FSM must be back in IDLE: a fresh load issues immediately.
    drive(16'h8840, 16'h0700, 16'h0000, 1, 0, 0, 0, 16'h0000);
    #1;
    chk("ra_fresh_en",    16'(mif.mem_en), 16'h1);
    chk("ra_fresh_stall", 16'(mem_stall), 16'h1);
    @(posedge clk);
    #1;
    drive(16'h8840, 16'h0700, 16'h0000, 1, 0, 0, 1, 16'h1357);
    #1;
    chk("ra_fresh_done_stall", 16'(mem_stall), 16'h0);
    @(posedge clk);
    #1;
    chk("ra_fresh_wdata",  WData_out, 16'h1357);
    chk("ra_fresh_regwrt", 16'(RegWrt_out), 16'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
